alu_decode_stage: RTL and testbench

Decode-stage block that sits in front of the backend ALU and produces its inputs. It accepts LA32R fixed-point instructions from fetch over a valid/ready handshake and reads the register file. Each instruction is decoded into the ALU's one-hot 14-bit op vector and its two 32-bit operands, and the decoded bundle is held in a two-entry skid buffer until execute accepts it.

---
 rtl/alu_decode_stage_pkg.sv | 51 +++++
 rtl/alu_decode_stage_if.sv | 31 +++
 rtl/alu_decode_stage_decode.sv | 75 +++++++
 rtl/alu_decode_stage.sv | 61 ++++++
 tb/tb_alu_decode_stage.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/alu_decode_stage_pkg.sv
// alu_decode_stage_pkg: shared ALU op encoding, LA32R opcodes and decoded-bundle type
package alu_decode_stage_pkg;
   localparam int OP_ADD  = 0;
   localparam int OP_IMM  = 1;
   localparam int OP_OR   = 2;
   localparam int OP_SUB  = 3;
   localparam int OP_XOR  = 4;
   localparam int OP_SRA  = 5;
   localparam int OP_AND  = 6;
   localparam int OP_SLL  = 7;
   localparam int OP_SRL  = 8;
   localparam int OP_SLTU = 9;
   localparam int OP_NOR  = 10;
   localparam int OP_SLT  = 11;
   typedef logic [13:0] alu_op_t;
   localparam logic [16:0] OPC_ADD_W  = 17'h00020;
   localparam logic [16:0] OPC_SUB_W  = 17'h00022;
   localparam logic [16:0] OPC_SLT    = 17'h00024;
   localparam logic [16:0] OPC_SLTU   = 17'h00025;
   localparam logic [16:0] OPC_NOR    = 17'h00028;
   localparam logic [16:0] OPC_AND    = 17'h00029;
   localparam logic [16:0] OPC_OR     = 17'h0002A;
   localparam logic [16:0] OPC_XOR    = 17'h0002B;
   localparam logic [16:0] OPC_SLL_W  = 17'h0002E;
   localparam logic [16:0] OPC_SRL_W  = 17'h0002F;
   localparam logic [16:0] OPC_SRA_W  = 17'h00030;
   localparam logic [16:0] OPC_SLLI_W = 17'h00081;
   localparam logic [16:0] OPC_SRLI_W = 17'h00089;
   localparam logic [16:0] OPC_SRAI_W = 17'h00091;
   localparam logic [9:0]  OPC_SLTI   = 10'h008;
   localparam logic [9:0]  OPC_SLTUI  = 10'h009;
   localparam logic [9:0]  OPC_ADDI_W = 10'h00A;
   localparam logic [9:0]  OPC_ANDI   = 10'h00D;
   localparam logic [9:0]  OPC_ORI    = 10'h00E;
   localparam logic [9:0]  OPC_XORI   = 10'h00F;
   localparam logic [6:0]  OPC_LU12I_W   = 7'h0A;
   localparam logic [6:0]  OPC_PCADDU12I = 7'h0E;
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} buf_state_t;
   typedef struct packed {
      logic [31:0] pc;
      alu_op_t     op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } bundle_t;
   function automatic alu_op_t op_bit(input int idx);
      return 14'd1 << idx;
   endfunction
endpackage

// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if: fetch, register-file and execute signals of the decode stage
interface alu_decode_stage_if;
   import alu_decode_stage_pkg::*;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   alu_op_t     out_alu_op;
   logic [31:0] out_alu_src1;
   logic [31:0] out_alu_src2;
   logic [4:0]  out_rd;
   logic        out_rf_we;
   logic        out_illegal;
   modport slave (
      input  in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2, out_ready,
      output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_alu_op,
             out_alu_src1, out_alu_src2, out_rd, out_rf_we, out_illegal
   );
   modport master (
      output in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2, out_ready,
      input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_alu_op,
             out_alu_src1, out_alu_src2, out_rd, out_rf_we, out_illegal
   );
endinterface

// File: rtl/alu_decode_stage_decode.sv
// alu_inst_decode: combinational LA32R fixed-point decode into an ALU bundle
module alu_inst_decode
   import alu_decode_stage_pkg::*;
(
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rdata1,
   input  logic [31:0] i_rdata2,
   output bundle_t     o_bundle
);
   logic [16:0] w_op17;
   logic [9:0]  w_op10;
   logic [6:0]  w_op7;
   logic [31:0] w_rj_val, w_rk_val, w_si12, w_ui12, w_ui20, w_shamt_i, w_shamt_r;
   logic [31:0] w_src1, w_src2;
   alu_op_t     w_op;
   logic        w_illegal;
   assign w_op17    = i_inst[31:15];
   assign w_op10    = i_inst[31:22];
   assign w_op7     = i_inst[31:25];
   assign w_rj_val  = (i_inst[9:5] == 5'd0) ? 32'd0 : i_rdata1;
   assign w_rk_val  = (i_inst[14:10] == 5'd0) ? 32'd0 : i_rdata2;
   assign w_si12    = {{20{i_inst[21]}}, i_inst[21:10]};
   assign w_ui12    = {20'd0, i_inst[21:10]};
   assign w_ui20    = {i_inst[24:5], 12'd0};
   assign w_shamt_i = {27'd0, i_inst[14:10]};
   // the ALU's sra consumes all of src2, so shift amounts are masked here
   assign w_shamt_r = {27'd0, w_rk_val[4:0]};
   always_comb begin
      w_op   = '0;
      w_src1 = w_rj_val;
      w_src2 = w_rk_val;
      case (w_op17)
         OPC_ADD_W:  w_op = op_bit(OP_ADD);
         OPC_SUB_W:  w_op = op_bit(OP_SUB);
         OPC_SLT:    w_op = op_bit(OP_SLT);
         OPC_SLTU:   w_op = op_bit(OP_SLTU);
         OPC_NOR:    w_op = op_bit(OP_NOR);
         OPC_AND:    w_op = op_bit(OP_AND);
         OPC_OR:     w_op = op_bit(OP_OR);
         OPC_XOR:    w_op = op_bit(OP_XOR);
         OPC_SLL_W:  begin w_op = op_bit(OP_SLL); w_src2 = w_shamt_r; end
         OPC_SRL_W:  begin w_op = op_bit(OP_SRL); w_src2 = w_shamt_r; end
         OPC_SRA_W:  begin w_op = op_bit(OP_SRA); w_src2 = w_shamt_r; end
         OPC_SLLI_W: begin w_op = op_bit(OP_SLL); w_src2 = w_shamt_i; end
         OPC_SRLI_W: begin w_op = op_bit(OP_SRL); w_src2 = w_shamt_i; end
         OPC_SRAI_W: begin w_op = op_bit(OP_SRA); w_src2 = w_shamt_i; end
         default: ;
      endcase
      case (w_op10)
         OPC_SLTI:   begin w_op = op_bit(OP_SLT);  w_src2 = w_si12; end
         OPC_SLTUI:  begin w_op = op_bit(OP_SLTU); w_src2 = w_si12; end
         OPC_ADDI_W: begin w_op = op_bit(OP_ADD);  w_src2 = w_si12; end
         OPC_ANDI:   begin w_op = op_bit(OP_AND);  w_src2 = w_ui12; end
         OPC_ORI:    begin w_op = op_bit(OP_OR);   w_src2 = w_ui12; end
         OPC_XORI:   begin w_op = op_bit(OP_XOR);  w_src2 = w_ui12; end
         default: ;
      endcase
      case (w_op7)
         OPC_LU12I_W:   begin w_op = op_bit(OP_IMM); w_src1 = w_ui20; w_src2 = '0; end
         OPC_PCADDU12I: begin w_op = op_bit(OP_ADD); w_src1 = i_pc;   w_src2 = w_ui20; end
         default: ;
      endcase
   end
   assign w_illegal = (w_op == '0);
   assign o_bundle = '{
      pc:      i_pc,
      op:      w_op,
      src1:    w_illegal ? 32'd0 : w_src1,
      src2:    w_illegal ? 32'd0 : w_src2,
      rd:      i_inst[4:0],
      we:      !w_illegal && (i_inst[4:0] != 5'd0),
      illegal: w_illegal
   };
endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes fetch beats into ALU bundles held in a two-entry skid buffer
module alu_decode_stage
   import alu_decode_stage_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   alu_decode_stage_if.slave   bus
);
   buf_state_t r_state;
   bundle_t    r_main, r_skid, w_dec;
   logic       w_accept, w_fire;
   alu_inst_decode u_decode (
      .i_inst   (bus.in_inst),
      .i_pc     (bus.in_pc),
      .i_rdata1 (bus.rf_rdata1),
      .i_rdata2 (bus.rf_rdata2),
      .o_bundle (w_dec)
   );
   assign bus.rf_raddr1    = bus.in_inst[9:5];
   assign bus.rf_raddr2    = bus.in_inst[14:10];
   assign bus.in_ready     = !reset && (r_state != S_FULL);
   assign bus.out_valid    = (r_state != S_EMPTY);
   assign bus.out_pc       = r_main.pc;
   assign bus.out_alu_op   = r_main.op;
   assign bus.out_alu_src1 = r_main.src1;
   assign bus.out_alu_src2 = r_main.src2;
   assign bus.out_rd       = r_main.rd;
   assign bus.out_rf_we    = r_main.we;
   assign bus.out_illegal  = r_main.illegal;
   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_fire   = bus.out_valid && bus.out_ready;
   // r_main always drives the outputs; r_skid only catches a beat accepted while stalled
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_state <= S_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            S_EMPTY: if (w_accept) begin
               r_main  <= w_dec;
               r_state <= S_ONE;
            end
            S_ONE: if (w_accept && w_fire) begin
               r_main  <= w_dec;
            end else if (w_fire) begin
               r_state <= S_EMPTY;
            end else if (w_accept) begin
               r_skid  <= w_dec;
               r_state <= S_FULL;
            end
            S_FULL: if (w_fire) begin
               r_main  <= r_skid;
               r_state <= S_ONE;
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: scoreboard bench for the decode stage with directed LA32R vectors
module tb_alu_decode_stage;
   import alu_decode_stage_pkg::*;
   logic clk = 1'b0;
   logic reset, flush;
   int   n_pass = 0, n_total = 0;
   bundle_t sb[$];
   bundle_t e, g;
   logic [31:0] regs [32];
   logic [31:0] v_inst [14];
   bundle_t     v_exp  [14];
   alu_decode_stage_if bus();
   alu_decode_stage dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
   always #5 clk = ~clk;
   always_comb begin
      bus.rf_rdata1 = regs[bus.rf_raddr1];
      bus.rf_rdata2 = regs[bus.rf_raddr2];
   end
   function automatic bundle_t mk(input logic [31:0] pc, input logic [13:0] op,
                                  input logic [31:0] s1, input logic [31:0] s2,
                                  input logic [4:0] rd, input logic we, input logic ill);
      return '{pc, op, s1, s2, rd, we, ill};
   endfunction
   function automatic logic [31:0] rr(input logic [16:0] op, input logic [4:0] rk, input logic [4:0] rj, input logic [4:0] rd);
      return {op, rk, rj, rd};
   endfunction
   function automatic logic [31:0] i12(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rj, input logic [4:0] rd);
      return {op, imm, rj, rd};
   endfunction
   function automatic logic [31:0] i20(input logic [6:0] op, input logic [19:0] imm, input logic [4:0] rd);
      return {op, imm, rd};
   endfunction
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, got, exp);
   endtask
   task automatic send(input logic [31:0] inst, input bundle_t x);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_pc    = x.pc;
      bus.in_inst  = inst;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (ok) sb.push_back(x);
      else begin
         n_total++;
         $display("FAIL send_timeout: pc %h never accepted", x.pc);
      end
   endtask
   task automatic drain(input string name);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
      #1;
      chk(name, sb.size(), 0);
   endtask
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         n_total++;
         g = '{bus.out_pc, bus.out_alu_op, bus.out_alu_src1, bus.out_alu_src2,
               bus.out_rd, bus.out_rf_we, bus.out_illegal};
         if (sb.size() == 0) begin
            $display("FAIL unexpected_beat: got pc %h, required no beat", bus.out_pc);
         end else begin
            e = sb.pop_front();
            if (g.pc == e.pc && g.op == e.op && g.rd == e.rd && g.we == e.we && g.illegal == e.illegal
                && (e.illegal || (g.src1 == e.src1 && g.src2 == e.src2)))
               n_pass++;
            else
               $display("FAIL beat_pc_%h: got op %h s1 %h s2 %h rd %0d we %b ill %b required op %h s1 %h s2 %h rd %0d we %b ill %b",
                        e.pc, g.op, g.src1, g.src2, g.rd, g.we, g.illegal,
                        e.op, e.src1, e.src2, e.rd, e.we, e.illegal);
         end
      end
   end
   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      regs[0] = 32'hDEADBEEF; regs[1] = 32'd5; regs[2] = 32'd7; regs[6] = 32'd10;
      regs[7] = 32'h21; regs[8] = 32'h80000000; regs[9] = 32'hFFFFFFF0;
      v_inst[0]  = rr(OPC_ADD_W, 5'd2, 5'd1, 5'd3);   v_exp[0]  = mk(32'h1000, 14'h0001, 32'd5, 32'd7, 5'd3, 1, 0);
      v_inst[1]  = i12(OPC_ADDI_W, 12'hFFF, 5'd6, 5'd4); v_exp[1] = mk(32'h1004, 14'h0001, 32'd10, 32'hFFFFFFFF, 5'd4, 1, 0);
      v_inst[2]  = 32'h142468A5;                       v_exp[2]  = mk(32'h1008, 14'h0002, 32'h12345000, 32'h0, 5'd5, 1, 0);
      v_inst[3]  = rr(OPC_SRA_W, 5'd7, 5'd8, 5'd10);  v_exp[3]  = mk(32'h100C, 14'h0020, 32'h80000000, 32'h1, 5'd10, 1, 0);
      v_inst[4]  = 32'hFFFFFFFF;                       v_exp[4]  = mk(32'h1010, 14'h0000, 32'h0, 32'h0, 5'd31, 0, 1);
      v_inst[5]  = rr(OPC_SUB_W, 5'd2, 5'd1, 5'd11);  v_exp[5]  = mk(32'h1014, 14'h0008, 32'd5, 32'd7, 5'd11, 1, 0);
      v_inst[6]  = i12(OPC_SLTI, 12'hFFB, 5'd9, 5'd12); v_exp[6] = mk(32'h1018, 14'h0800, 32'hFFFFFFF0, 32'hFFFFFFFB, 5'd12, 1, 0);
      v_inst[7]  = i12(OPC_ANDI, 12'hFFF, 5'd9, 5'd13); v_exp[7] = mk(32'h101C, 14'h0040, 32'hFFFFFFF0, 32'h00000FFF, 5'd13, 1, 0);
      v_inst[8]  = i20(OPC_PCADDU12I, 20'hFFFFF, 5'd14); v_exp[8] = mk(32'h1020, 14'h0001, 32'h1020, 32'hFFFFF000, 5'd14, 1, 0);
      v_inst[9]  = rr(OPC_SRLI_W, 5'd31, 5'd8, 5'd15); v_exp[9] = mk(32'h1024, 14'h0100, 32'h80000000, 32'd31, 5'd15, 1, 0);
      v_inst[10] = rr(OPC_OR, 5'd1, 5'd0, 5'd0);      v_exp[10] = mk(32'h1028, 14'h0004, 32'd0, 32'd5, 5'd0, 0, 0);
      v_inst[11] = rr(OPC_SLTU, 5'd0, 5'd1, 5'd16);   v_exp[11] = mk(32'h102C, 14'h0200, 32'd5, 32'd0, 5'd16, 1, 0);
      v_inst[12] = rr(OPC_NOR, 5'd9, 5'd2, 5'd17);    v_exp[12] = mk(32'h1030, 14'h0400, 32'd7, 32'hFFFFFFF0, 5'd17, 1, 0);
      v_inst[13] = rr(OPC_SLL_W, 5'd9, 5'd1, 5'd18);  v_exp[13] = mk(32'h1034, 14'h0080, 32'd5, 32'h10, 5'd18, 1, 0);
      reset = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("in_ready_during_reset", {31'd0, bus.in_ready}, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_out_valid", {31'd0, bus.out_valid}, 0);
      chk("reset_in_ready", {31'd0, bus.in_ready}, 1);
      chk("reset_out_pc", bus.out_pc, 0);
      chk("reset_out_op", {18'd0, bus.out_alu_op}, 0);
      for (int i = 0; i < 14; i++) send(v_inst[i], v_exp[i]);
      drain("drain_directed");
      bus.out_ready = 1'b0;
      fork
         begin
            send(rr(OPC_ADD_W, 5'd2, 5'd1, 5'd20), mk(32'h2000, 14'h0001, 32'd5, 32'd7, 5'd20, 1, 0));
            send(rr(OPC_ADD_W, 5'd2, 5'd1, 5'd21), mk(32'h2004, 14'h0001, 32'd5, 32'd7, 5'd21, 1, 0));
            chk("in_ready_when_full", {31'd0, bus.in_ready}, 0);
            send(rr(OPC_ADD_W, 5'd2, 5'd1, 5'd22), mk(32'h2008, 14'h0001, 32'd5, 32'd7, 5'd22, 1, 0));
            send(rr(OPC_ADD_W, 5'd2, 5'd1, 5'd23), mk(32'h200C, 14'h0001, 32'd5, 32'd7, 5'd23, 1, 0));
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain("drain_backpressure");
      bus.out_ready = 1'b0;
      send(rr(OPC_XOR, 5'd2, 5'd1, 5'd24), mk(32'h3000, 14'h0010, 32'd5, 32'd7, 5'd24, 1, 0));
      send(rr(OPC_XOR, 5'd2, 5'd1, 5'd25), mk(32'h3004, 14'h0010, 32'd5, 32'd7, 5'd25, 1, 0));
      sb.delete();
      bus.in_valid = 1'b1; bus.in_pc = 32'h3008; bus.in_inst = rr(OPC_XOR, 5'd2, 5'd1, 5'd26);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
      chk("flush_in_ready", {31'd0, bus.in_ready}, 1);
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      bus.out_ready = 1'b0;
      send(rr(OPC_AND, 5'd2, 5'd1, 5'd27), mk(32'h4000, 14'h0040, 32'd5, 32'd7, 5'd27, 1, 0));
      bus.in_valid = 1'b0;
      sb.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset_out_valid", {31'd0, bus.out_valid}, 0);
      chk("midreset_out_pc", bus.out_pc, 0);
      bus.out_ready = 1'b1;
      send(rr(OPC_OR, 5'd2, 5'd1, 5'd28), mk(32'h5000, 14'h0004, 32'd5, 32'd7, 5'd28, 1, 0));
      drain("drain_final");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
